// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS8 (x^8+x^4+x^3+x^2+1) stream checker with hunt/verify/lock and windowed lock-loss
module prbs_predict (
  input  logic [7:0] h,
  output logic       pred
);

  // Next bit of the sequence from the 8-bit history (h[0] = most recent bit)
  assign pred = h[3] ^ h[4] ^ h[5] ^ h[7];

endmodule

module prbs_checker #(
  parameter int VERIFY_LEN = 16,
  parameter int WIN_LEN    = 32,
  parameter int MAX_ERR    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        prbs_in,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  localparam int MW = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN) : 1;
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(VERIFY_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(MAX_ERR - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      h_q, h_d;
  logic [2:0]      fill_q, fill_d;
  logic [MW-1:0]   match_q, match_d;
  logic [WW-1:0]   win_q, win_d;
  logic [EW-1:0]   werr_q, werr_d;
  logic [15:0]     err_count_q, err_count_d;
  logic            err_pulse_q, err_pulse_d;
  logic            locked_q, locked_d;

  logic            pred;
  logic            mismatch;
  logic [7:0]      h_rx;
  logic [7:0]      h_pred;

  prbs_predict u_predict (
    .h    (h_q),
    .pred (pred)
  );

  assign mismatch = prbs_in ^ pred;
  assign h_rx     = {h_q[6:0], prbs_in};
  assign h_pred   = {h_q[6:0], pred};

  // Next-state and next-counter logic; everything holds unless a valid bit arrives
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          h_d = h_rx;
          if (fill_q == 3'd7) begin
            // History is full; an all-zero history cannot seed the sequence, so keep sliding
            if (h_rx != 8'd0) begin
              state_d = VERIFY;
              fill_d  = 3'd0;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        VERIFY: begin
          h_d = h_rx;
          if (mismatch) begin
            state_d = HUNT;
            fill_d  = 3'd0;
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end

        LOCKED: begin
          // Free-run on our own prediction so a single line error is not propagated
          h_d = h_pred;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
          end
          if (mismatch && (werr_q == ERR_LAST)) begin
            state_d = HUNT;
            fill_d  = 3'd0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            // An error on the last bit is already accounted for above; the window then restarts
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            if (mismatch) begin
              werr_d = werr_q + EW'(1);
            end
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = 3'd0;
          match_d = '0;
          win_d   = '0;
          werr_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State, history, counters and registered outputs; reset overrides any valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      h_q         <= 8'd0;
      fill_q      <= 3'd0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_count_q <= 16'd0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - bench for prbs_checker against a bit-history reference model
module tb_prbs_checker;

  localparam int VERIFY_LEN = 16;
  localparam int WIN_LEN    = 32;
  localparam int MAX_ERR    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        prbs_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  // generator state for the transmitted sequence
  logic [7:0] g = 8'hFF;

  // reference model: last 8 bits the checker should be tracking, oldest first
  bit m_rx[$];
  int m_mode;
  int m_seen;
  int m_match;
  int m_pos;
  int m_werr;
  int m_errs;
  bit m_pulse;

  prbs_checker #(
    .VERIFY_LEN (VERIFY_LEN),
    .WIN_LEN    (WIN_LEN),
    .MAX_ERR    (MAX_ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .prbs_in   (prbs_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_one();
    foreach (m_rx[i]) if (m_rx[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_bit(input bit b);
    m_rx.push_back(b);
    void'(m_rx.pop_front());
  endtask

  task automatic model_step(input bit r, input bit e, input bit b);
    bit p;
    if (r) begin
      m_rx.delete();
      repeat (8) m_rx.push_back(1'b0);
      m_mode = 0; m_seen = 0; m_match = 0; m_pos = 0; m_werr = 0;
      m_errs = 0; m_pulse = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    if (!e) return;
    // b[n] = b[n-4] ^ b[n-5] ^ b[n-6] ^ b[n-8]
    p = m_rx[4] ^ m_rx[3] ^ m_rx[2] ^ m_rx[0];
    if (m_mode == 0) begin
      push_bit(b);
      m_seen++;
      if (m_seen >= 8 && any_one()) begin
        m_mode = 1; m_match = 0;
      end
    end else if (m_mode == 1) begin
      push_bit(b);
      if (b == p) begin
        m_match++;
        if (m_match == VERIFY_LEN) begin
          m_mode = 2; m_match = 0; m_pos = 0; m_werr = 0;
        end
      end else begin
        m_mode = 0; m_seen = 0; m_match = 0;
      end
    end else begin
      push_bit(p);
      if (b != p) begin
        m_pulse = 1'b1;
        if (m_errs < 65535) m_errs++;
        m_werr++;
        if (m_werr == MAX_ERR) begin
          m_mode = 0; m_seen = 0; m_match = 0; m_pos = 0; m_werr = 0;
          return;
        end
      end
      m_pos++;
      if (m_pos == WIN_LEN) begin
        m_pos = 0; m_werr = 0;
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit b);
    rst = r; en = e; prbs_in = b;
    @(posedge clk);
    #1;
    model_step(r, e, b);
    check("state", state, m_mode);
    check("locked", locked, (m_mode == 2) ? 1 : 0);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_errs);
  endtask

  task automatic send(input bit flip);
    bit nb;
    nb = g[3] ^ g[4] ^ g[5] ^ g[7];
    g = {g[6:0], nb};
    tick(1'b0, 1'b1, nb ^ flip);
  endtask

  task automatic relock();
    tick(1'b1, 1'b0, 1'b0);
    repeat (8 + VERIFY_LEN) send(1'b0);
    check("relock", locked, 1);
  endtask

  initial begin
    int nv;
    int lock_at;
    int pulses;
    bit flag;
    bit nb;

    rst = 1'b1; en = 1'b0; prbs_in = 1'b0;

    // reset then idle with en=0
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);

    // clean stream, one valid bit every 4th clock
    nv = 0; lock_at = 0;
    while (nv < 2000) begin
      send(1'b0);
      nv++;
      if (locked === 1'b1 && lock_at == 0) lock_at = nv;
      repeat (3) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    check("lock_at", lock_at, 8 + VERIFY_LEN);
    check("lock_count", err_count, 0);
    check("lock_held", locked, 1);

    // single inverted bit
    relock();
    repeat (10) send(1'b0);
    send(1'b1);
    pulses = (err_pulse === 1'b1) ? 1 : 0;
    repeat (100) begin
      send(1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    check("single_pulses", pulses, 1);
    check("single_count", err_count, 1);
    check("single_locked", locked, 1);

    // four errors in one window
    relock();
    for (int k = 0; k <= 6; k++) send((k % 2) == 0);
    check("loss_state", state, 0);
    for (int i = 1; i <= 8 + VERIFY_LEN; i++) begin
      send(1'b0);
      if (i == 8 + VERIFY_LEN - 1) check("loss_not_yet", locked, 0);
    end
    check("loss_relock", locked, 1);
    check("loss_count", err_count, 4);

    // three errors per window across a boundary, one on the last bit of the first
    relock();
    flag = 1'b0;
    for (int k = 0; k < 2 * WIN_LEN; k++) begin
      send(k == 5 || k == 20 || k == 31 || k == 35 || k == 42 || k == 49);
      if (locked !== 1'b1) flag = 1'b1;
    end
    check("win_lost", flag, 0);
    check("win_count", err_count, 6);

    // constant zero never leaves HUNT
    tick(1'b1, 1'b0, 1'b0);
    flag = 1'b0;
    repeat (200) begin
      tick(1'b0, 1'b1, 1'b0);
      if (state !== 2'd0) flag = 1'b1;
    end
    check("zero_hunt", flag, 0);

    // constant one: 9th bit mismatches, never locks
    tick(1'b1, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b1, 1'b1);
    check("ones_verify", state, 1);
    tick(1'b0, 1'b1, 1'b1);
    check("ones_ninth", state, 0);
    flag = 1'b0;
    repeat (200) begin
      tick(1'b0, 1'b1, 1'b1);
      if (locked !== 1'b0) flag = 1'b1;
    end
    check("ones_never", flag, 0);

    // random valid strobe and sparse random errors
    tick(1'b1, 1'b0, 1'b0);
    repeat (3000) begin
      if ($urandom_range(0, 3) != 0) send($urandom_range(0, 19) == 0);
      else tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    // reset while locked with a simultaneous error
    relock();
    send(1'b1);
    repeat (5) send(1'b0);
    check("mid_pre_count", err_count, 1);
    nb = g[3] ^ g[4] ^ g[5] ^ g[7];
    g = {g[6:0], nb};
    tick(1'b1, 1'b1, ~nb);
    check("mid_locked", locked, 0);
    check("mid_pulse", err_pulse, 0);
    check("mid_count", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 The block SHALL have parameter VERIFY_LEN, default 16: consecutive matching bits needed in VERIFY before lock.
REQ-002 The block SHALL have parameter WIN_LEN, default 32: valid bits per lock-loss window in LOCKED.
REQ-003 The block SHALL have parameter MAX_ERR, default 4: errors within one window that force loss of lock.
REQ-004 The block SHALL have port clk, input, 1 bit: 100 MHz master clock; the only clock in the block.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-006 The block SHALL have port en, input, 1 bit: bit-valid strobe; prbs_in is sampled only on clk edges where en=1.
REQ-007 The block SHALL have port prbs_in, input, 1 bit: received pseudo-random bit stream.
REQ-008 The block SHALL have port locked, output, 1 bit: 1 while in LOCKED.
REQ-009 The block SHALL have port err_pulse, output, 1 bit: one-cycle flag for each bit error detected in LOCKED.
REQ-010 The block SHALL have port err_count, output, 16 bits: saturating count of bit errors detected in LOCKED.
REQ-011 The block SHALL have port state, output, 2 bits: current state (HUNT=0, VERIFY=1, LOCKED=2).

Function
REQ-012 The reference sequence SHALL use polynomial x^8+x^4+x^3+x^2+1: predicted bit = h[3]^h[4]^h[5]^h[7], where h[7:0] is the bit history and h[0] is the most recent bit.
REQ-013 On every valid bit, h SHALL shift left with the new bit entering h[0]; when en=0, h, all counters, and state SHALL hold.
REQ-014 In HUNT and VERIFY, the received bit SHALL be shifted into h; in LOCKED, the predicted bit SHALL be shifted into h, so each line error counts exactly once.
REQ-015 In HUNT, a fill counter SHALL count valid bits; on the valid bit that completes 8 bits, the block SHALL go to VERIFY only if the updated h is nonzero.
REQ-016 If the updated h is all-zero at that point, the block SHALL stay in HUNT and re-evaluate on each subsequent valid bit.
REQ-017 In VERIFY, each valid bit SHALL be compared with the prediction; a match SHALL increment the match counter.
REQ-018 In VERIFY, VERIFY_LEN matches SHALL cause a transition to LOCKED.
REQ-019 In VERIFY, any mismatch SHALL cause a return to HUNT with the fill and match counters cleared.
REQ-020 In LOCKED, a mismatch SHALL assert err_pulse for exactly one clk cycle, on the cycle after the sampling edge.
REQ-021 In LOCKED, a mismatch SHALL increment err_count, saturating at 16'hFFFF with no wrap.
REQ-022 In LOCKED, a mismatch SHALL increment the window error counter.
REQ-023 In LOCKED, the window counter SHALL count valid bits from 0 to WIN_LEN-1 and then wrap; the window error counter SHALL clear on wrap.
REQ-024 If an error falls on the last bit of a window, it SHALL count in the ending window, and both window counters SHALL then clear.
REQ-025 On the MAX_ERR-th error within one window, the block SHALL go to HUNT; all internal counters SHALL clear, and err_count SHALL be retained.
REQ-026 err_pulse and err_count SHALL never change in HUNT or VERIFY.
REQ-027 err_count SHALL persist across loss of lock and relock, and SHALL clear only on reset.
REQ-028 All outputs SHALL be registered; locked and state SHALL update on the cycle after the deciding valid bit.
REQ-029 With an error-free stream, latency from the first valid bit to locked=1 SHALL be 8+VERIFY_LEN valid bits plus one clk cycle.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL set state=HUNT, locked=0, err_pulse=0, err_count=0, h=0, and clear all internal counters.
REQ-031 rst SHALL take priority over en, including in mid-LOCKED and on a simultaneous error.
REQ-032 The block SHALL contain no asynchronous logic and no derived clocks; all flops SHALL be clocked by clk.

Verification
REQ-033 Reset scenario: rst=1 for 2 cycles, then en=0 -> locked=0, state=0, err_pulse=0, err_count=0, held indefinitely.
REQ-034 Lock scenario: reference LFSR seeded 8'hFF feeds prbs_in with en=1 every 4th clk -> locked=1 one cycle after the 24th valid bit; err_count=0 after 2000 valid bits.
REQ-035 Single-error scenario: after lock, invert one bit -> exactly one err_pulse cycle, err_count=1, locked stays 1, and no further errors follow.
REQ-036 Lock-loss scenario: after lock, invert 4 bits within one 32-bit window -> err_count=4, state=HUNT after the 4th error, relock after 24 more valid bits, err_count still 4.
REQ-037 Window-boundary scenario: 3 errors in window N, then 3 errors in window N+1 (one on bit 31 of N) -> no lock loss, err_count=6.
REQ-038 Degenerate-input scenario: constant 0 input -> stays in HUNT forever; constant 1 input -> 9th bit mismatches (predicted 0), never reaches LOCKED.
REQ-039 Mid-operation reset scenario: rst in LOCKED with en=1 and a simultaneous error -> next cycle locked=0, err_pulse=0, err_count=0.
